// File: rtl/riscv_pkg.sv
// Shared RV32M types: funct3 operation codes, unit FSM states and division corner-case constants.
package riscv_pkg;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } muldiv_op_t;

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        DIV,
        DONE
    } muldiv_state_t;

    localparam logic [31:0] DIV_BY_ZERO_Q = 32'hFFFF_FFFF;
    localparam logic [31:0] INT_MIN       = 32'h8000_0000;

endpackage

// File: rtl/execute_muldiv_unit_if.sv
// Execute-stage <-> mul/div unit bundle: instruction request, pipeline controls, result and freeze request.
interface execute_muldiv_unit_if #(
    parameter int DATA_WIDTH = 32
) ();
    logic                   start;
    riscv_pkg::muldiv_op_t  op;
    logic [DATA_WIDTH-1:0]  src_a;
    logic [DATA_WIDTH-1:0]  src_b;
    logic                   flush;
    logic                   stall;
    logic                   stall_req;
    logic                   done;
    logic [DATA_WIDTH-1:0]  result;

    modport master (
        output start, op, src_a, src_b, flush, stall,
        input  stall_req, done, result
    );

    modport slave (
        input  start, op, src_a, src_b, flush, stall,
        output stall_req, done, result
    );
endinterface

// File: rtl/muldiv_divider_core.sv
// Unsigned radix-2 restoring divider, one quotient bit per cycle, MSB first; a start reloads it at any time.
// busy drops during the final iteration so the caller can leave its wait state on the edge the last bit lands.
module muldiv_divider_core #(
    parameter int DATA_WIDTH = 32,
    parameter int DIV_CYCLES = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] dividend,
    input  logic [DATA_WIDTH-1:0] divisor,
    output logic                  busy,
    output logic [DATA_WIDTH-1:0] quotient,
    output logic [DATA_WIDTH-1:0] remainder
);
    localparam int              CW       = $clog2(DIV_CYCLES);
    localparam logic [CW-1:0]   LAST_CNT = CW'(DIV_CYCLES - 1);

    logic                  run_q, run_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] quo_q, quo_d;
    logic [DATA_WIDTH-1:0] rem_q, rem_d;
    logic [DATA_WIDTH-1:0] dvs_q, dvs_d;
    logic [DATA_WIDTH:0]   rem_shift;

    always_comb begin
        run_d     = run_q;
        cnt_d     = cnt_q;
        quo_d     = quo_q;
        rem_d     = rem_q;
        dvs_d     = dvs_q;
        rem_shift = {rem_q, quo_q[DATA_WIDTH-1]};
        if (start) begin
            run_d = 1'b1;
            cnt_d = '0;
            quo_d = dividend;
            rem_d = '0;
            dvs_d = divisor;
        end else if (run_q) begin
            // The dividend shifts out of quo_q as quotient bits shift in.
            if (rem_shift >= {1'b0, dvs_q}) begin
                rem_d = DATA_WIDTH'(rem_shift - {1'b0, dvs_q});
                quo_d = {quo_q[DATA_WIDTH-2:0], 1'b1};
            end else begin
                rem_d = rem_shift[DATA_WIDTH-1:0];
                quo_d = {quo_q[DATA_WIDTH-2:0], 1'b0};
            end
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LAST_CNT) begin
                run_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            run_q <= 1'b0;
            cnt_q <= '0;
            quo_q <= '0;
            rem_q <= '0;
            dvs_q <= '0;
        end else begin
            run_q <= run_d;
            cnt_q <= cnt_d;
            quo_q <= quo_d;
            rem_q <= rem_d;
            dvs_q <= dvs_d;
        end
    end

    assign busy      = run_q && (cnt_q != LAST_CNT);
    assign quotient  = quo_q;
    assign remainder = rem_q;

endmodule

// File: rtl/execute_muldiv_unit.sv
// Iterative RV32M multiply/divide for the execute stage: MUL result 2 cycles after start, DIV/REM 33, corner cases 1.
// Freezes upstream via stall_req while computing; a finished result is held in DONE for as long as stall is high.
module execute_muldiv_unit
    import riscv_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DIV_CYCLES = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    execute_muldiv_unit_if.slave   mdu
);
    muldiv_state_t         state_q, state_d;
    muldiv_op_t            op_q, op_d;
    logic [DATA_WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
    logic                  use_div_q, use_div_d;
    logic                  neg_quo_q, neg_quo_d, neg_rem_q, neg_rem_d;

    logic                  div_start, div_busy, sgn_div;
    logic [DATA_WIDTH-1:0] mag_a, mag_b, div_quo, div_rem, div_res;
    logic                  a_sx, b_sx;
    logic signed [2*DATA_WIDTH-1:0] a_ext, b_ext, prod;

    // Signed divide works on magnitudes; INT_MIN negates to itself, which is its correct unsigned magnitude.
    assign sgn_div = !mdu.op[0];
    assign mag_a   = (sgn_div && mdu.src_a[DATA_WIDTH-1]) ? -mdu.src_a : mdu.src_a;
    assign mag_b   = (sgn_div && mdu.src_b[DATA_WIDTH-1]) ? -mdu.src_b : mdu.src_b;

    assign a_sx  = (op_q != OP_MULHU) && a_q[DATA_WIDTH-1];
    assign b_sx  = (op_q == OP_MUL || op_q == OP_MULH) && b_q[DATA_WIDTH-1];
    assign a_ext = {{DATA_WIDTH{a_sx}}, a_q};
    assign b_ext = {{DATA_WIDTH{b_sx}}, b_q};
    assign prod  = a_ext * b_ext;

    muldiv_divider_core #(
        .DATA_WIDTH (DATA_WIDTH),
        .DIV_CYCLES (DIV_CYCLES)
    ) u_divider (
        .clk       (clk),
        .reset     (reset),
        .start     (div_start),
        .dividend  (mag_a),
        .divisor   (mag_b),
        .busy      (div_busy),
        .quotient  (div_quo),
        .remainder (div_rem)
    );

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        a_d       = a_q;
        b_d       = b_q;
        res_d     = res_q;
        use_div_d = use_div_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        div_start = 1'b0;
        case (state_q)
            IDLE: begin
                if (mdu.start && !mdu.flush) begin
                    op_d      = mdu.op;
                    a_d       = mdu.src_a;
                    b_d       = mdu.src_b;
                    use_div_d = 1'b0;
                    if (!mdu.op[2]) begin
                        state_d = MUL;
                    end else if (mdu.src_b == '0) begin
                        res_d   = mdu.op[1] ? mdu.src_a : DIV_BY_ZERO_Q;
                        state_d = DONE;
                    end else if (sgn_div && mdu.src_a == INT_MIN && mdu.src_b == DIV_BY_ZERO_Q) begin
                        res_d   = mdu.op[1] ? '0 : INT_MIN;
                        state_d = DONE;
                    end else begin
                        div_start = 1'b1;
                        use_div_d = 1'b1;
                        neg_quo_d = sgn_div && (mdu.src_a[DATA_WIDTH-1] ^ mdu.src_b[DATA_WIDTH-1]);
                        neg_rem_d = sgn_div && mdu.src_a[DATA_WIDTH-1];
                        state_d   = DIV;
                    end
                end
            end
            MUL: begin
                if (mdu.flush) begin
                    state_d = IDLE;
                end else begin
                    res_d   = (op_q == OP_MUL) ? prod[DATA_WIDTH-1:0] : prod[2*DATA_WIDTH-1:DATA_WIDTH];
                    state_d = DONE;
                end
            end
            DIV: begin
                if (mdu.flush) begin
                    state_d = IDLE;
                end else if (!div_busy) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (mdu.flush || !mdu.stall) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            op_q      <= OP_MUL;
            a_q       <= '0;
            b_q       <= '0;
            res_q     <= '0;
            use_div_q <= 1'b0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            a_q       <= a_d;
            b_q       <= b_d;
            res_q     <= res_d;
            use_div_q <= use_div_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
        end
    end

    // Divider outputs are final and frozen once DONE is reached, so the sign fix-up is applied on read.
    assign div_res = op_q[1] ? (neg_rem_q ? -div_rem : div_rem)
                             : (neg_quo_q ? -div_quo : div_quo);

    assign mdu.done      = (state_q == DONE);
    assign mdu.result    = (state_q != DONE) ? '0 : (use_div_q ? div_res : res_q);
    assign mdu.stall_req = (state_q == IDLE && mdu.start && !mdu.flush && reset)
                         || state_q == MUL || state_q == DIV;

endmodule

// File: tb/tb_execute_muldiv_unit.sv
// Directed-vector bench for execute_muldiv_unit: latency, results, corner cases, stall hold, flush and reset.
module tb_execute_muldiv_unit;
    import riscv_pkg::*;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   errors = 0;

    execute_muldiv_unit_if #(.DATA_WIDTH(32)) mdu_if ();

    execute_muldiv_unit #(
        .DATA_WIDTH (32),
        .DIV_CYCLES (32)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .mdu   (mdu_if.slave)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    // Called on a falling edge with the unit idle; returns on the falling edge of the DONE cycle.
    task automatic run_op(input string tag, input muldiv_op_t op, input logic [31:0] a,
                          input logic [31:0] b, input int exp_lat, input logic [31:0] exp_res);
        int n;
        mdu_if.start = 1'b1;
        mdu_if.op    = op;
        mdu_if.src_a = a;
        mdu_if.src_b = b;
        #1;
        check_eq({tag, "_req_t0"}, {31'd0, mdu_if.stall_req}, 32'd1);
        @(negedge clk);
        mdu_if.start = 1'b0;
        n = 1;
        check_eq({tag, "_req_t1"}, {31'd0, mdu_if.stall_req}, (exp_lat > 1) ? 32'd1 : 32'd0);
        while (mdu_if.done !== 1'b1 && n < 64) begin
            @(negedge clk);
            n++;
        end
        check_eq({tag, "_lat"}, n, exp_lat);
        check_eq({tag, "_res"}, mdu_if.result, exp_res);
        check_eq({tag, "_req_done"}, {31'd0, mdu_if.stall_req}, 32'd0);
    endtask

    task automatic to_idle(input string tag);
        @(negedge clk);
        check_eq({tag, "_idle_done"}, {31'd0, mdu_if.done}, 32'd0);
        check_eq({tag, "_idle_res"}, mdu_if.result, 32'd0);
    endtask

    initial begin
        int hits;
        mdu_if.start = 1'b0;
        mdu_if.op    = OP_MUL;
        mdu_if.src_a = '0;
        mdu_if.src_b = '0;
        mdu_if.flush = 1'b0;
        mdu_if.stall = 1'b0;

        #12;
        check_eq("rst_done", {31'd0, mdu_if.done}, 32'd0);
        check_eq("rst_req",  {31'd0, mdu_if.stall_req}, 32'd0);
        check_eq("rst_res",  mdu_if.result, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        run_op("mul",    OP_MUL,    32'h0000_0007, 32'hFFFF_FFFD, 2,  32'hFFFF_FFEB); to_idle("mul");
        run_op("mulm1",  OP_MUL,    32'hFFFF_FFFF, 32'hFFFF_FFFF, 2,  32'h0000_0001); to_idle("mulm1");
        run_op("mulh",   OP_MULH,   32'h8000_0000, 32'h8000_0000, 2,  32'h4000_0000); to_idle("mulh");
        run_op("mulhu",  OP_MULHU,  32'h8000_0000, 32'h8000_0000, 2,  32'h4000_0000); to_idle("mulhu");
        run_op("mulhsu", OP_MULHSU, 32'h8000_0000, 32'h8000_0000, 2,  32'hC000_0000); to_idle("mulhsu");
        run_op("div",    OP_DIV,    32'hFFFF_FFEC, 32'h0000_0003, 33, 32'hFFFF_FFFA); to_idle("div");
        run_op("rem",    OP_REM,    32'hFFFF_FFEC, 32'h0000_0003, 33, 32'hFFFF_FFFE); to_idle("rem");
        run_op("div_nb", OP_DIV,    32'h0000_0007, 32'hFFFF_FFFE, 33, 32'hFFFF_FFFD); to_idle("div_nb");
        run_op("rem_nb", OP_REM,    32'h0000_0007, 32'hFFFF_FFFE, 33, 32'h0000_0001); to_idle("rem_nb");
        run_op("divu",   OP_DIVU,   32'd100,       32'd7,         33, 32'd14);        to_idle("divu");
        run_op("remu",   OP_REMU,   32'd100,       32'd7,         33, 32'd2);         to_idle("remu");
        run_op("div_z",  OP_DIV,    32'd5,         32'd0,         1,  32'hFFFF_FFFF); to_idle("div_z");
        run_op("remu_z", OP_REMU,   32'd5,         32'd0,         1,  32'd5);         to_idle("remu_z");
        run_op("div_ov", OP_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 1,  32'h8000_0000); to_idle("div_ov");
        run_op("rem_ov", OP_REM,    32'h8000_0000, 32'hFFFF_FFFF, 1,  32'h0000_0000); to_idle("rem_ov");

        // Result must hold through four stalled cycles, then retire one cycle after stall drops.
        run_op("stall", OP_DIVU, 32'd100, 32'd7, 33, 32'd14);
        for (int i = 0; i < 4; i++) begin
            check_eq($sformatf("stall_done%0d", i), {31'd0, mdu_if.done}, 32'd1);
            check_eq($sformatf("stall_res%0d", i), mdu_if.result, 32'd14);
            mdu_if.stall = 1'b1;
            @(negedge clk);
        end
        mdu_if.stall = 1'b0;
        check_eq("stall_rel_done", {31'd0, mdu_if.done}, 32'd1);
        check_eq("stall_rel_res", mdu_if.result, 32'd14);
        to_idle("stall");

        // Flush in the tenth cycle of a divide.
        mdu_if.start = 1'b1;
        mdu_if.op    = OP_DIV;
        mdu_if.src_a = 32'hFFFF_FFEC;
        mdu_if.src_b = 32'd3;
        @(negedge clk);
        mdu_if.start = 1'b0;
        repeat (9) @(negedge clk);
        mdu_if.flush = 1'b1;
        #1;
        check_eq("flush_req_t10", {31'd0, mdu_if.stall_req}, 32'd1);
        @(negedge clk);
        mdu_if.flush = 1'b0;
        check_eq("flush_req_t11", {31'd0, mdu_if.stall_req}, 32'd0);
        check_eq("flush_done_t11", {31'd0, mdu_if.done}, 32'd0);
        hits = 0;
        repeat (30) begin
            @(negedge clk);
            if (mdu_if.done !== 1'b0 || mdu_if.stall_req !== 1'b0) hits++;
        end
        check_eq("flush_quiet", hits, 32'd0);

        // start together with flush in IDLE is dropped.
        mdu_if.start = 1'b1;
        mdu_if.flush = 1'b1;
        mdu_if.op    = OP_MUL;
        mdu_if.src_a = 32'd3;
        mdu_if.src_b = 32'd4;
        #1;
        check_eq("sflush_req", {31'd0, mdu_if.stall_req}, 32'd0);
        @(negedge clk);
        mdu_if.start = 1'b0;
        mdu_if.flush = 1'b0;
        #1;
        check_eq("sflush_req_t1", {31'd0, mdu_if.stall_req}, 32'd0);
        @(negedge clk);
        check_eq("sflush_done_t2", {31'd0, mdu_if.done}, 32'd0);

        // Asynchronous reset in the middle of a divide.
        mdu_if.start = 1'b1;
        mdu_if.op    = OP_DIVU;
        mdu_if.src_a = 32'd100;
        mdu_if.src_b = 32'd7;
        @(negedge clk);
        mdu_if.start = 1'b0;
        repeat (5) @(negedge clk);
        check_eq("arst_pre_req", {31'd0, mdu_if.stall_req}, 32'd1);
        #2 reset = 1'b0;
        #1;
        check_eq("arst_req", {31'd0, mdu_if.stall_req}, 32'd0);
        check_eq("arst_done", {31'd0, mdu_if.done}, 32'd0);
        check_eq("arst_res", mdu_if.result, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        run_op("post_rst", OP_MUL, 32'd6, 32'd7, 2, 32'd42);
        to_idle("post_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/execute_muldiv_unit.md
Name: execute_muldiv_unit

Overview:
- Iterative RV32M multiply/divide unit inside the execute stage.
- Its result feeds the execute-to-memory pipeline register as ALUResultM, in place of the ALU result when op is M-extension.
- Raises stall_req to freeze upstream stages while computing.
- Honours the pipeline-wide stall (e.g. cache_miss from the memory stage) by holding its finished result.

Parameters:
DATA_WIDTH, 32, operand/result width
DIV_CYCLES, 32, divider iterations (must equal DATA_WIDTH)

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-low reset (asserted when 0)
start  input  1  valid M-extension instruction present in execute stage
op  input  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
src_a  input  DATA_WIDTH  rs1 value (after forwarding)
src_b  input  DATA_WIDTH  rs2 value (after forwarding)
flush  input  1  squash in-flight operation (branch mispredict)
stall  input  1  global pipeline stall (memory-stage cache miss)
stall_req  output  1  hold fetch/decode/execute this cycle
done  output  1  result valid this cycle
result  output  DATA_WIDTH  operation result

Behaviour:
- Reset (reset=0, async): state=IDLE; done=0; stall_req=0; result=0; counter=0; operand/partial registers=0.
- FSM states: IDLE, MUL, DIV, DONE.
- IDLE + start at cycle T:
  - Latch op, src_a, src_b.
  - MUL ops go to MUL.
  - DIV/REM special cases go directly to DONE.
  - All other DIV/REM ops go to DIV.
  - stall_req=1 combinationally in cycle T.
- MUL (cycle T+1):
  - Form a 33x33 signed product, sign-extending per op (MULHSU: a signed, b unsigned; MULHU: both zero-extended).
  - Register the product; go to DONE.
  - MUL returns bits[31:0]; MULH/MULHSU/MULHU return bits[63:32].
  - Result at T+2.
- DIV (cycles T+1..T+32):
  - Radix-2 restoring division on magnitudes, MSB first, one bit per cycle; counter 0..31.
  - After the 32nd iteration go to DONE.
  - Signed fix-up on exit: quotient negated if signs of operands differ; remainder takes the dividend's sign.
  - Result at T+33.
- Special cases, decided at start, DONE at T+1:
  - Divide by zero: DIV/DIVU quotient = all ones; REM/REMU = src_a.
  - Signed overflow (src_a = 0x8000_0000, src_b = 0xFFFF_FFFF, DIV/REM only): DIV = 0x8000_0000; REM = 0.
- DONE:
  - done=1, stall_req=0, result held stable.
  - If stall=1: stay in DONE, result unchanged.
  - Else: IDLE next edge; the pipeline register captures result on that edge.
- stall_req = (IDLE & start & ~flush) | MUL | DIV.
- start while not IDLE: ignored; the upstream freeze guarantees the same instruction is presented.
- flush (highest priority, any state): IDLE next edge, done=0, no result produced. flush together with start in IDLE: start ignored.
- stall during MUL/DIV: computation continues; completion waits in DONE.
- Back-to-back: a start arriving in the cycle the unit returns to IDLE is accepted normally.
- result is 0 outside DONE.

Decomposition:
- Shared package riscv_pkg holds:
  - muldiv_op_t enum (the 8 funct3 codes)
  - muldiv_state_t enum (IDLE, MUL, DIV, DONE)
  - constants DIV_BY_ZERO_Q = 32'hFFFF_FFFF and INT_MIN = 32'h8000_0000
- One natural sub-module, muldiv_divider_core:
  - Iterative unsigned restoring divider with its own counter.
  - Ports: start, dividend, divisor, busy, quotient, remainder.
  - The top handles sign pre/post-processing, the multiplier, the FSM and stall logic.

Test Plan:
- MUL: start op=000, a=0x0000_0007, b=0xFFFF_FFFD -> stall_req=1 in T and T+1; done=1 at T+2; result=0xFFFF_FFEB.
- MULH/MULHU/MULHSU with a=b=0x8000_0000 -> 0x4000_0000, 0x4000_0000, 0xC000_0000 respectively.
- DIV a=0xFFFF_FFEC (-20), b=3 -> done at T+33, result 0xFFFF_FFFA (-6); REM same operands -> 0xFFFF_FFFE (-2); DIVU 100/7 -> 14, REMU -> 2.
- Specials:
  - DIV a=5, b=0 -> done at T+1, result 0xFFFF_FFFF; REMU a=5, b=0 -> 5.
  - DIV 0x8000_0000 / 0xFFFF_FFFF -> 0x8000_0000; REM -> 0.
- stall held 4 cycles on reaching DONE of DIVU 100/7 -> done=1 and result=14 stable across all 4 cycles; IDLE one cycle after stall drops.
- Interruptions:
  - flush at T+10 of a DIV -> IDLE at T+11, done never asserted, stall_req=0 from T+11.
  - reset asserted mid-DIV -> all outputs 0 immediately, without a clock edge.
